pixel_sequencer: RTL and testbench
==================================

PIXEL_SEQUENCER -- requirements
Module: pixel_sequencer

Interface
REQ-001 Parameter ERASE_CYCLES, default 5: cycles ERASE is held high per frame, legal range 1..65535.
REQ-002 Parameter EXPOSE_CYCLES, default 255: cycles EXPOSE is held high per frame, legal range 1..65535.
REQ-003 Parameter CONVERT_CYCLES, default 255: cycles CONVERT is held high per frame (one RAMP pulse per code), legal range 1..65535.
REQ-004 Parameter READ_CYCLES, default 5: cycles READ is held high per frame, legal range 1..65535.
REQ-005 CLK  in  1  single clock; all state changes on rising edge.
REQ-006 RESET  in  1  synchronous, active-high reset.
REQ-007 START  in  1  request one frame; sampled only in IDLE.
REQ-008 READY  in  1  downstream readout can accept a frame; gates entry to READ.
REQ-009 ERASE  out  1  pixel erase control.
REQ-010 EXPOSE  out  1  pixel expose control.
REQ-011 CONVERT  out  1  ADC conversion enable.
REQ-012 RAMP  out  1  conversion step strobe; toggles every cycle while CONVERT is high, starting at 1.
REQ-013 READ  out  1  pixel readout strobe to the array.
REQ-014 BUSY  out  1  high in every state except IDLE.
REQ-015 FRAME_DONE  out  1  one-cycle pulse on the cycle after the last READ cycle.

Function
REQ-016 States: IDLE, ERASE, EXPOSE, CONVERT, WAIT_RDY, READ.
- Exactly one state is active per cycle.
- All outputs are registered and decoded from the state.
REQ-017 IDLE->ERASE on the clock edge where START=1.
- ERASE is high on the next cycle, giving 1-cycle latency from START.
REQ-018 Each timed state loads a 16-bit down-counter with its parameter minus 1 on entry.
- It decrements every cycle.
- On the cycle the counter equals 0, the state advances, so the output is high for exactly the parameter count of cycles.
REQ-019 Transitions: ERASE->EXPOSE->CONVERT.
- CONVERT->READ if READY=1 on its final cycle, else CONVERT->WAIT_RDY.
REQ-020 WAIT_RDY holds every control output low.
- It stays until READY=1, then goes to READ on the next edge.
REQ-021 READ->IDLE after READ_CYCLES cycles.
- FRAME_DONE=1 for the first IDLE cycle only.
REQ-022 RAMP is held 0 outside CONVERT.
- RAMP is 1 on the first CONVERT cycle and alternates thereafter.
- CONVERT_CYCLES=255 therefore yields 128 rising RAMP edges.
REQ-023 At most one of ERASE, EXPOSE, CONVERT, READ is high in any cycle, with no overlap at transitions.
REQ-024 START while BUSY=1 is ignored and not queued.
REQ-025 READY is ignored outside the final CONVERT cycle and WAIT_RDY.
- Deassertion of READY during READ does not abort READ.
REQ-026 START=1 held continuously in IDLE starts a new frame on the cycle after FRAME_DONE, with no extra idle cycle required.

Reset
REQ-027 RESET=1 on any rising edge forces IDLE.
- It zeroes the counter and drives ERASE, EXPOSE, CONVERT, RAMP, READ, BUSY and FRAME_DONE to 0 on the following cycle.
- Reset takes priority over START and over any in-progress state.
REQ-028 Reset mid-frame does not produce a FRAME_DONE pulse.
- The first frame after RESET deasserts requires a fresh START (or CONTINUOUS mode per REQ-030).

Configuration
REQ-029 Macro PIXEL_SEQ_CONTINUOUS_EN, when undefined, gives behaviour exactly as REQ-017..REQ-028.
REQ-030 When PIXEL_SEQ_CONTINUOUS_EN is defined, IDLE is left unconditionally after one cycle, ignoring START.
- Frames repeat back-to-back.
- BUSY is low only for the single IDLE cycle carrying FRAME_DONE.
- On RESET release, IDLE is held for one cycle, then ERASE.

Verification
V1 RESET 1 for 2 cycles, then START pulse, READY=1, default params -> ERASE 5, EXPOSE 255, CONVERT 255, READ 5 cycles, FRAME_DONE one cycle later; total BUSY = 520 cycles.
V2 READY=0 through CONVERT, released 10 cycles after CONVERT ends -> 10 WAIT_RDY cycles with all controls low, then READ 5 cycles; BUSY = 530 cycles.
V3 START pulsed during EXPOSE and during READ -> ignored; exactly one FRAME_DONE, and IDLE remains after it.
V4 RESET asserted in cycle 100 of CONVERT -> next cycle all outputs 0, state IDLE, no FRAME_DONE; new START gives a full normal frame.
V5 CONVERT_CYCLES=255 -> count rising RAMP edges = 128, RAMP=0 in every non-CONVERT cycle; one-hot check of controls every cycle.
V6 PIXEL_SEQ_CONTINUOUS_EN defined, START tied 0, READY=1 -> three consecutive frames, FRAME_DONE spaced 521 cycles apart.

Source files
------------

// File: rtl/pixel_sequencer.sv
// pixel_sequencer: frame timing FSM for erase/expose/convert/read phases.
// Define PIXEL_SEQ_CONTINUOUS_EN for free-running back-to-back frames.
module pixel_sequencer #(
    parameter int unsigned ERASE_CYCLES   = 5,
    parameter int unsigned EXPOSE_CYCLES  = 255,
    parameter int unsigned CONVERT_CYCLES = 255,
    parameter int unsigned READ_CYCLES    = 5
) (
    input  logic CLK,
    input  logic RESET,
    input  logic START,
    input  logic READY,
    output logic ERASE,
    output logic EXPOSE,
    output logic CONVERT,
    output logic RAMP,
    output logic READ,
    output logic BUSY,
    output logic FRAME_DONE
);

    localparam logic [15:0] ERASE_LD   = 16'(ERASE_CYCLES - 1);
    localparam logic [15:0] EXPOSE_LD  = 16'(EXPOSE_CYCLES - 1);
    localparam logic [15:0] CONVERT_LD = 16'(CONVERT_CYCLES - 1);
    localparam logic [15:0] READ_LD    = 16'(READ_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERASE,
        ST_EXPOSE,
        ST_CONVERT,
        ST_WAIT_RDY,
        ST_READ
    } state_t;

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic        last;
    logic        erase_n, expose_n, convert_n, ramp_n;
    logic        read_n, busy_n, done_n;

    assign last = (cnt == 16'd0);

`ifdef PIXEL_SEQ_CONTINUOUS_EN
    logic unused_start;
    assign unused_start = START;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = last ? 16'd0 : cnt - 16'd1;
        unique case (state)
            ST_IDLE: begin
`ifdef PIXEL_SEQ_CONTINUOUS_EN
                state_n = ST_ERASE;
                cnt_n   = ERASE_LD;
`else
                if (START) begin
                    state_n = ST_ERASE;
                    cnt_n   = ERASE_LD;
                end
`endif
            end
            ST_ERASE: begin
                if (last) begin
                    state_n = ST_EXPOSE;
                    cnt_n   = EXPOSE_LD;
                end
            end
            ST_EXPOSE: begin
                if (last) begin
                    state_n = ST_CONVERT;
                    cnt_n   = CONVERT_LD;
                end
            end
            ST_CONVERT: begin
                if (last) begin
                    if (READY) begin
                        state_n = ST_READ;
                        cnt_n   = READ_LD;
                    end else begin
                        state_n = ST_WAIT_RDY;
                    end
                end
            end
            ST_WAIT_RDY: begin
                if (READY) begin
                    state_n = ST_READ;
                    cnt_n   = READ_LD;
                end
            end
            ST_READ: begin
                if (last) state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = 16'd0;
            end
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        erase_n   = (state_n == ST_ERASE);
        expose_n  = (state_n == ST_EXPOSE);
        convert_n = (state_n == ST_CONVERT);
        read_n    = (state_n == ST_READ);
        busy_n    = (state_n != ST_IDLE);
        done_n    = (state == ST_READ) && (state_n == ST_IDLE);
        ramp_n    = convert_n && ((state != ST_CONVERT) || !RAMP);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= ST_IDLE;
            cnt        <= 16'd0;
            ERASE      <= 1'b0;
            EXPOSE     <= 1'b0;
            CONVERT    <= 1'b0;
            RAMP       <= 1'b0;
            READ       <= 1'b0;
            BUSY       <= 1'b0;
            FRAME_DONE <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            ERASE      <= erase_n;
            EXPOSE     <= expose_n;
            CONVERT    <= convert_n;
            RAMP       <= ramp_n;
            READ       <= read_n;
            BUSY       <= busy_n;
            FRAME_DONE <= done_n;
        end
    end

endmodule

// File: tb/tb_pixel_sequencer.sv
// tb_pixel_sequencer: randomized frames checked against a phase-segment model.
// Build with PIXEL_SEQ_CONTINUOUS_EN to exercise the free-running mode.
`timescale 1ns/1ps
module tb_pixel_sequencer;

    localparam int E = 5;
    localparam int X = 255;
    localparam int C = 255;
    localparam int R = 5;

    // Bit order: ERASE, EXPOSE, CONVERT, READ, BUSY, FRAME_DONE
    localparam logic [5:0] V_ERASE   = 6'b100010;
    localparam logic [5:0] V_EXPOSE  = 6'b010010;
    localparam logic [5:0] V_CONVERT = 6'b001010;
    localparam logic [5:0] V_WAIT    = 6'b000010;
    localparam logic [5:0] V_READ    = 6'b000110;
    localparam logic [5:0] V_DONE    = 6'b000001;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic START = 1'b0;
    logic READY = 1'b0;
    logic ERASE, EXPOSE, CONVERT, RAMP, READ, BUSY, FRAME_DONE;

    always #5 CLK = ~CLK;

    pixel_sequencer #(
        .ERASE_CYCLES  (E),
        .EXPOSE_CYCLES (X),
        .CONVERT_CYCLES(C),
        .READ_CYCLES   (R)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .START     (START),
        .READY     (READY),
        .ERASE     (ERASE),
        .EXPOSE    (EXPOSE),
        .CONVERT   (CONVERT),
        .RAMP      (RAMP),
        .READ      (READ),
        .BUSY      (BUSY),
        .FRAME_DONE(FRAME_DONE)
    );

    typedef struct {
        logic [5:0] v;
        int         n;
    } seg_t;

    seg_t       exp_q[$];
    int         n_tests = 0;
    int         n_fail = 0;
    bit         mon_en = 1'b0;
    logic [5:0] cur = 6'd0;
    logic [5:0] mv;
    int         len = 0;
    int         rises = 0;
    logic       ramp_prev = 1'b0;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // A frame is a run of phases with known lengths; a reset after k busy
    // cycles cuts the run short and drops the FRAME_DONE cycle.
    function automatic void push_frame(input int w, input int k);
        logic [5:0] v[5];
        int         l[5];
        int         left;
        seg_t       s;
        v[0] = V_ERASE;   l[0] = E;
        v[1] = V_EXPOSE;  l[1] = X;
        v[2] = V_CONVERT; l[2] = C;
        v[3] = V_WAIT;    l[3] = w;
        v[4] = V_READ;    l[4] = R;
        left = (k == 0) ? E + X + C + w + R + 1 : k;
        for (int i = 0; i < 5; i++) begin
            int n;
            n = (l[i] < left) ? l[i] : left;
            if (n > 0) begin
                s.v = v[i];
                s.n = n;
                exp_q.push_back(s);
            end
            left -= n;
        end
        if (left > 0) begin
            s.v = V_DONE;
            s.n = 1;
            exp_q.push_back(s);
        end
    endfunction

    task automatic seg_done(input logic [5:0] v, input int n, input int r);
        seg_t s;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL seg_extra: got vec %b len %0d, required no segment", v, n);
        end else begin
            s = exp_q.pop_front();
            chk("seg_vec", int'(v), int'(s.v));
            chk("seg_len", n, s.n);
        end
        if (v[3]) chk("ramp_rises", r, (n + 1) / 2);
    endtask

    always @(negedge CLK) begin
        if (mon_en) begin
            mv = {ERASE, EXPOSE, CONVERT, READ, BUSY, FRAME_DONE};
            if (mv != cur) begin
                if (cur != 6'd0) seg_done(cur, len, rises);
                cur   = mv;
                len   = 1;
                rises = 0;
            end else begin
                len++;
            end
            if (RAMP && !ramp_prev) rises++;
            ramp_prev = RAMP;
            chk("ramp", int'(RAMP), int'(mv[3] && (len % 2 == 1)));
            chk("onehot", int'($countones(mv[5:2]) > 1), 0);
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            START = 1'b0;
            READY = 1'($urandom_range(0, 1));
            @(posedge CLK);
            #1;
        end
    endtask

    // w: WAIT_RDY cycles; k: busy cycle carrying RESET (0 = none).
    task automatic run_frame(input int w, input int k);
        int b;
        int ecx;
        ecx = E + X + C;
        b   = ecx + w + R;
        push_frame(w, k);
        START = 1'b1;
        READY = 1'($urandom_range(0, 1));
        @(posedge CLK);
        #1;
        for (int i = 1; i <= b; i++) begin
            START = ($urandom_range(0, 7) == 0);
            if (i >= ecx && i < ecx + w) READY = 1'b0;
            else if (i == ecx + w)       READY = 1'b1;
            else                         READY = 1'($urandom_range(0, 1));
            RESET = (i == k);
            @(posedge CLK);
            #1;
            if (RESET) begin
                RESET = 1'b0;
                break;
            end
        end
        START = 1'b0;
    endtask

    initial begin
`ifdef PIXEL_SEQ_CONTINUOUS_EN
        RESET = 1'b1;
        START = 1'b0;
        READY = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RESET  = 1'b0;
        mon_en = 1'b1;
        for (int f = 0; f < 3; f++) push_frame(0, 0);
        push_frame(0, 50);
        repeat (1613) begin
            @(posedge CLK);
            #1;
        end
        RESET = 1'b1;
        repeat (4) begin
            @(posedge CLK);
            #1;
        end
`else
        RESET = 1'b1;
        START = 1'b1;
        READY = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        START = 1'b0;
        @(negedge CLK);
        chk("reset_outs", int'({ERASE, EXPOSE, CONVERT, RAMP, READ, BUSY, FRAME_DONE}), 0);
        @(posedge CLK);
        #1;
        mon_en = 1'b1;
        run_frame(0, 0);
        idle(4);
        run_frame(10, 0);
        idle(3);
        run_frame(0, 0);
        idle(6);
        run_frame(0, E + X + 100);
        idle(2);
        run_frame(0, 0);
        for (int f = 0; f < 12; f++) begin
            int w;
            int k;
            w = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 12) : 0;
            k = ($urandom_range(0, 3) == 0) ? $urandom_range(1, E + X + C + w + R) : 0;
            run_frame(w, k);
            idle($urandom_range(0, 3));
        end
        idle(4);
`endif
        @(negedge CLK);
        chk("seg_left", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
